// File: rtl/fetch.sv
// Instruction fetch unit: reads two big-endian bytes from synchronous program RAM,
// presents the 16-bit instruction with valid/ready and owns the program counter.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_START     | idle; launch fetch of pc when fetch_en=1
// S_REQ_HI    | RAM samples pc; present pc+1
// S_REQ_LO    | high byte returned and latched; RAM samples pc+1
// S_CAP_LO    | low byte returned; assemble instr, pc += 2
// S_HOLD      | instr_valid held until instr_ready
// S_WAIT_NEXT | wait for next pulse (advance / skip / load)
module fetch #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] PC_RESET = 'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              next,
    input  logic              skip,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_START,
        S_REQ_HI,
        S_REQ_LO,
        S_CAP_LO,
        S_HOLD,
        S_WAIT_NEXT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd_en;
    logic [7:0]        r_hi;
    logic [15:0]       r_instr;
    logic              r_instr_valid;
    logic              r_busy;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_plus2;

    assign w_pc_plus1 = r_pc + ADDR_W'(1);
    assign w_pc_plus2 = r_pc + ADDR_W'(2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_START:     if (fetch_en) w_state_nxt = S_REQ_HI;
            S_REQ_HI:    w_state_nxt = S_REQ_LO;
            S_REQ_LO:    w_state_nxt = S_CAP_LO;
            S_CAP_LO:    w_state_nxt = S_HOLD;
            S_HOLD:      if (instr_ready) w_state_nxt = S_WAIT_NEXT;
            S_WAIT_NEXT: if (next) w_state_nxt = S_START;
            default:     w_state_nxt = S_START;
        endcase
    end

    // Registered outputs; busy follows the next state so it lines up with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= PC_RESET;
            r_mem_addr    <= '0;
            r_mem_rd_en   <= 1'b0;
            r_hi          <= 8'h00;
            r_instr       <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_START) && (w_state_nxt != S_WAIT_NEXT);
            case (r_state)
                S_START: begin
                    if (fetch_en) begin
                        r_mem_addr  <= r_pc;
                        r_mem_rd_en <= 1'b1;
                    end else begin
                        r_mem_rd_en <= 1'b0;
                    end
                end
                S_REQ_HI: r_mem_addr <= w_pc_plus1;
                S_REQ_LO: begin
                    r_hi        <= mem_rd_data;
                    r_mem_rd_en <= 1'b0;
                end
                S_CAP_LO: begin
                    r_instr       <= {r_hi, mem_rd_data};
                    r_instr_valid <= 1'b1;
                    r_pc          <= w_pc_plus2;
                end
                S_HOLD: if (instr_ready) r_instr_valid <= 1'b0;
                S_WAIT_NEXT: begin
                    if (next) begin
                        if (pc_load)   r_pc <= pc_load_addr;
                        else if (skip) r_pc <= w_pc_plus2;
                    end
                end
                default: r_mem_rd_en <= 1'b0;
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_rd_en   = r_mem_rd_en;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign busy        = r_busy;

endmodule

// File: tb/tb_fetch.sv
// Scoreboarded bench for fetch: behavioural program RAM, directed fetch/skip/load
// sequences; a negedge monitor checks every accepted instruction against the queue.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        next;
    logic        skip;
    logic        pc_load;
    logic [11:0] pc_load_addr;
    logic [11:0] pc;
    logic        busy;

    typedef struct packed {
        logic [15:0] instr;
        logic [11:0] pc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] ram [0:4095];
    int         n_checks;
    int         n_fail;

    fetch #(.ADDR_W(12), .PC_RESET(12'h200)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .next         (next),
        .skip         (skip),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .pc           (pc),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM: data appears the cycle after rd_en is sampled.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr: got %0h expected none", instr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_instr", {16'h0, instr}, {16'h0, e.instr});
                chk("sb_pc", {20'h0, pc}, {20'h0, e.pc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_next(input logic sk, input logic ld, input logic [11:0] a,
                           input logic [11:0] exp_pc);
        next         = 1'b1;
        skip         = sk;
        pc_load      = ld;
        pc_load_addr = a;
        step();
        next    = 1'b0;
        skip    = 1'b0;
        pc_load = 1'b0;
        chk("next_pc", {20'h0, pc}, {20'h0, exp_pc});
        chk("next_busy", {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!instr_valid && k < 20) begin
            step();
            k++;
        end
        if (!instr_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: got instr_valid=0 expected 1 within 20 cycles");
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        fetch_en     = 1'b0;
        instr_ready  = 1'b0;
        next         = 1'b0;
        skip         = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 12'h000;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h200] = 8'h00; ram[12'h201] = 8'hE0;
        ram[12'h202] = 8'hAA; ram[12'h203] = 8'hBB;
        ram[12'h204] = 8'h6A; ram[12'h205] = 8'h12;
        ram[12'h300] = 8'hA5; ram[12'h301] = 8'h5A;
        ram[12'h302] = 8'hD0; ram[12'h303] = 8'h1F;
        ram[12'hFFF] = 8'h12; ram[12'h000] = 8'h34;

        repeat (2) step();
        chk("rst_pc", {20'h0, pc}, 32'h200);
        chk("rst_addr", {20'h0, mem_addr}, 32'h0);
        chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // First fetch after reset, no next needed; valid 4 clocks after release.
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        sb_q.push_back({16'h00E0, 12'h202});
        rst = 1'b1;
        step();
        chk("t1_addr_hi", {20'h0, mem_addr}, 32'h200);
        chk("t1_rd_en_hi", {31'h0, mem_rd_en}, 32'h1);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        step();
        chk("t1_addr_lo", {20'h0, mem_addr}, 32'h201);
        chk("t1_rd_en_lo", {31'h0, mem_rd_en}, 32'h1);
        step();
        chk("t1_rd_en_off", {31'h0, mem_rd_en}, 32'h0);
        chk("t1_valid_early", {31'h0, instr_valid}, 32'h0);
        step();
        chk("t1_valid", {31'h0, instr_valid}, 32'h1);
        chk("t1_instr", {16'h0, instr}, 32'h00E0);
        chk("t1_pc", {20'h0, pc}, 32'h202);
        step();
        chk("t1_valid_pulse", {31'h0, instr_valid}, 32'h0);
        chk("t1_wait_busy", {31'h0, busy}, 32'h0);

        // Qualifiers without next are ignored.
        skip = 1'b1; pc_load = 1'b1; pc_load_addr = 12'h555;
        repeat (2) step();
        skip = 1'b0; pc_load = 1'b0;
        chk("qual_no_next_pc", {20'h0, pc}, 32'h202);
        chk("qual_no_next_rd", {31'h0, mem_rd_en}, 32'h0);

        // Skip to 0x204, with back-pressure and a stray next mid-fetch.
        instr_ready = 1'b0;
        sb_q.push_back({16'h6A12, 12'h206});
        do_next(1'b1, 1'b0, 12'h000, 12'h204);
        step();
        chk("skip_addr_hi", {20'h0, mem_addr}, 32'h204);
        step();
        chk("skip_addr_lo", {20'h0, mem_addr}, 32'h205);
        next = 1'b1; pc_load = 1'b1; pc_load_addr = 12'h777;
        step();
        next = 1'b0; pc_load = 1'b0;
        wait_valid();
        chk("busy_next_ignored", {20'h0, pc}, 32'h206);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'h0, instr_valid}, 32'h1);
            chk("bp_instr", {16'h0, instr}, 32'h6A12);
            chk("bp_rd_en", {31'h0, mem_rd_en}, 32'h0);
            step();
        end
        instr_ready = 1'b1;
        step();
        chk("bp_accepted", {31'h0, instr_valid}, 32'h0);

        // Load wins over skip.
        sb_q.push_back({16'hA55A, 12'h302});
        do_next(1'b1, 1'b1, 12'h300, 12'h300);
        wait_valid();
        step();

        // Plain next keeps pc.
        sb_q.push_back({16'hD01F, 12'h304});
        do_next(1'b0, 1'b0, 12'h000, 12'h302);
        wait_valid();
        step();

        // Wrap at the top of the address space.
        sb_q.push_back({16'h1234, 12'h001});
        do_next(1'b0, 1'b1, 12'hFFF, 12'hFFF);
        step();
        step();
        chk("wrap_addr_lo", {20'h0, mem_addr}, 32'h000);
        wait_valid();
        chk("wrap_pc", {20'h0, pc}, 32'h001);
        step();

        // Reset during REQ_LO aborts the fetch.
        do_next(1'b0, 1'b0, 12'h000, 12'h001);
        step();
        step();
        chk("abort_busy_pre", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_valid", {31'h0, instr_valid}, 32'h0);
        chk("abort_rd_en", {31'h0, mem_rd_en}, 32'h0);
        chk("abort_pc", {20'h0, pc}, 32'h200);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_addr", {20'h0, mem_addr}, 32'h0);
        step();
        sb_q.push_back({16'h00E0, 12'h202});
        rst = 1'b1;
        wait_valid();
        step();

        // fetch_en=0 holds in START.
        rst = 1'b0;
        #2;
        fetch_en = 1'b0;
        rst      = 1'b1;
        repeat (6) step();
        chk("stall_busy", {31'h0, busy}, 32'h0);
        chk("stall_rd_en", {31'h0, mem_rd_en}, 32'h0);
        chk("stall_valid", {31'h0, instr_valid}, 32'h0);
        chk("stall_pc", {20'h0, pc}, 32'h200);

        chk("sb_drained", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
